// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer: owns controlType while an op runs, times it, pulses HI/LO write.
// Optional abort input guarded by macro MD_SEQ_ABORT_EN (default build: no abort port).
module md_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_op,
    input  logic       divisor_zero,
`ifdef MD_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic [4:0] controlType,
    output logic       ct_valid,
    output logic       md_start,
    output logic       hilo_we,
    output logic       ack,
    output logic       busy,
    output logic       div0_exc
);

    localparam logic [4:0] CT_MULT = 5'b01010;
    localparam logic [4:0] CT_DIV  = 5'b01001;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_EXC   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             abort_w;

`ifdef MD_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // op is captured only on acceptance so late changes on req_op are harmless
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = req_op;
                    state_d = (req_op && divisor_zero) ? S_EXC : S_START;
                end
            end
            S_START: begin
                cnt_d   = op_q ? DIV_LOAD : MULT_LOAD;
                state_d = abort_w ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - 1'b1;
                if (abort_w)
                    state_d = S_IDLE;
                else if (cnt_q == '0)
                    state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        controlType = 5'b00000;
        ct_valid    = 1'b0;
        md_start    = 1'b0;
        hilo_we     = 1'b0;
        ack         = 1'b0;
        busy        = 1'b0;
        div0_exc    = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_START: begin
                controlType = op_q ? CT_DIV : CT_MULT;
                ct_valid    = 1'b1;
                md_start    = 1'b1;
                ack         = 1'b1;
                busy        = 1'b1;
            end
            S_RUN: begin
                controlType = op_q ? CT_DIV : CT_MULT;
                ct_valid    = 1'b1;
                busy        = 1'b1;
            end
            S_WRITE: begin
                controlType = op_q ? CT_DIV : CT_MULT;
                ct_valid    = 1'b1;
                hilo_we     = 1'b1;
                busy        = 1'b1;
            end
            S_EXC: begin
                div0_exc = 1'b1;
                ack      = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
